// File: rtl/dest_track_pipe.sv
// Carries decoded Rs/Rt/Rd, RegWrite and valid through ID/EX, EX/MEM and MEM/WB
// for the hazard unit, injects bubbles on stall/flush and watches stall runs.
module dest_track_pipe #(
    parameter int REG_W     = 3,
    parameter int CNT_W     = 16,
    parameter int STALL_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [REG_W-1:0] dec_rs,
    input  logic [REG_W-1:0] dec_rt,
    input  logic [REG_W-1:0] dec_rd,
    input  logic             dec_reg_write,
    input  logic             insert_nop,
    input  logic             flush,
    output logic [REG_W-1:0] id_ex_rs,
    output logic [REG_W-1:0] id_ex_rt,
    output logic [REG_W-1:0] id_ex_rd,
    output logic             id_ex_wr,
    output logic             id_ex_valid,
    output logic [REG_W-1:0] ex_mem_rs,
    output logic [REG_W-1:0] ex_mem_rt,
    output logic [REG_W-1:0] ex_mem_rd,
    output logic             ex_mem_wr,
    output logic             ex_mem_valid,
    output logic [REG_W-1:0] mem_wb_rs,
    output logic [REG_W-1:0] mem_wb_rt,
    output logic [REG_W-1:0] mem_wb_rd,
    output logic             mem_wb_wr,
    output logic             mem_wb_valid,
    output logic             fd_hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             stall_timeout
);

    typedef struct packed {
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
        logic             wr;
        logic             valid;
    } stage_t;

    typedef enum logic [1:0] {RUN, STALL, TIMEOUT} state_t;

    stage_t     id_ex_d, id_ex_q, ex_mem_q, mem_wb_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    state_t     state_d, state_q;
    logic [7:0] run_d, run_q;
    logic       timeout_d, timeout_q;

    // Gated by rst so the PC/IF-ID hold drops the moment reset asserts.
    assign fd_hold = rst & insert_nop & ~flush;

    always_comb begin
        // NOTE: default first so every path assigns id_ex_d; otherwise a latch is inferred.
        id_ex_d = '0;
        if (!flush && !insert_nop) begin
            id_ex_d.rs    = dec_rs;
            id_ex_d.rt    = dec_rt;
            id_ex_d.rd    = dec_rd;
            id_ex_d.valid = dec_valid;
            id_ex_d.wr    = dec_reg_write & dec_valid;
        end
    end

    assign cnt_d = (fd_hold && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        timeout_d = timeout_q;
        unique case (state_q)
            RUN: begin
                run_d = 8'd0;
                if (fd_hold) begin
                    if (STALL_MAX <= 1) begin
                        state_d   = TIMEOUT;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = STALL;
                        run_d   = 8'd1;
                    end
                end
            end
            STALL: begin
                if (!fd_hold) begin
                    state_d = RUN;
                    run_d   = 8'd0;
                end else if (int'(run_q) + 1 >= STALL_MAX) begin
                    state_d   = TIMEOUT;
                    run_d     = 8'd0;
                    timeout_d = 1'b1;
                end else begin
                    run_d = run_q + 8'd1;
                end
            end
            TIMEOUT: begin
                run_d = 8'd0;
                if (!fd_hold) state_d = RUN;
            end
            default: begin
                state_d = RUN;
                run_d   = 8'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_ex_q   <= '0;
            ex_mem_q  <= '0;
            mem_wb_q  <= '0;
            cnt_q     <= '0;
            state_q   <= RUN;
            run_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            id_ex_q   <= id_ex_d;
            ex_mem_q  <= id_ex_q;
            mem_wb_q  <= ex_mem_q;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            run_q     <= run_d;
            timeout_q <= timeout_d;
        end
    end

    assign id_ex_rs      = id_ex_q.rs;
    assign id_ex_rt      = id_ex_q.rt;
    assign id_ex_rd      = id_ex_q.rd;
    assign id_ex_wr      = id_ex_q.wr;
    assign id_ex_valid   = id_ex_q.valid;
    assign ex_mem_rs     = ex_mem_q.rs;
    assign ex_mem_rt     = ex_mem_q.rt;
    assign ex_mem_rd     = ex_mem_q.rd;
    assign ex_mem_wr     = ex_mem_q.wr;
    assign ex_mem_valid  = ex_mem_q.valid;
    assign mem_wb_rs     = mem_wb_q.rs;
    assign mem_wb_rt     = mem_wb_q.rt;
    assign mem_wb_rd     = mem_wb_q.rd;
    assign mem_wb_wr     = mem_wb_q.wr;
    assign mem_wb_valid  = mem_wb_q.valid;
    assign stall_cnt     = cnt_q;
    assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_dest_track_pipe.sv
// Scoreboard bench for dest_track_pipe: expected stage entries are queued as each
// decode cycle is driven and compared against all three stages after the edge.
module tb_dest_track_pipe;

    localparam int REG_W     = 3;
    localparam int CNT_W     = 4;
    localparam int STALL_MAX = 8;

    typedef struct packed {
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
        logic             wr;
        logic             valid;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             dec_valid = 1'b0;
    logic [REG_W-1:0] dec_rs = '0, dec_rt = '0, dec_rd = '0;
    logic             dec_reg_write = 1'b0;
    logic             insert_nop = 1'b0;
    logic             flush = 1'b0;
    logic [REG_W-1:0] id_ex_rs, id_ex_rt, id_ex_rd;
    logic             id_ex_wr, id_ex_valid;
    logic [REG_W-1:0] ex_mem_rs, ex_mem_rt, ex_mem_rd;
    logic             ex_mem_wr, ex_mem_valid;
    logic [REG_W-1:0] mem_wb_rs, mem_wb_rt, mem_wb_rd;
    logic             mem_wb_wr, mem_wb_valid;
    logic             fd_hold;
    logic [CNT_W-1:0] stall_cnt;
    logic             stall_timeout;

    int   total = 0;
    int   bad   = 0;
    ent_t exp_q[$];
    int   exp_cnt;
    logic exp_to;
    int   run_len;

    always #5 clk = ~clk;

    dest_track_pipe #(.REG_W(REG_W), .CNT_W(CNT_W), .STALL_MAX(STALL_MAX)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd),
        .dec_reg_write(dec_reg_write), .insert_nop(insert_nop), .flush(flush),
        .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
        .id_ex_wr(id_ex_wr), .id_ex_valid(id_ex_valid),
        .ex_mem_rs(ex_mem_rs), .ex_mem_rt(ex_mem_rt), .ex_mem_rd(ex_mem_rd),
        .ex_mem_wr(ex_mem_wr), .ex_mem_valid(ex_mem_valid),
        .mem_wb_rs(mem_wb_rs), .mem_wb_rt(mem_wb_rt), .mem_wb_rd(mem_wb_rd),
        .mem_wb_wr(mem_wb_wr), .mem_wb_valid(mem_wb_valid),
        .fd_hold(fd_hold), .stall_cnt(stall_cnt), .stall_timeout(stall_timeout)
    );

    wire ent_t id_ex_obs  = {id_ex_rs, id_ex_rt, id_ex_rd, id_ex_wr, id_ex_valid};
    wire ent_t ex_mem_obs = {ex_mem_rs, ex_mem_rt, ex_mem_rd, ex_mem_wr, ex_mem_valid};
    wire ent_t mem_wb_obs = {mem_wb_rs, mem_wb_rt, mem_wb_rd, mem_wb_wr, mem_wb_valid};

    task automatic model_reset();
        exp_q.delete();
        repeat (3) exp_q.push_back('0);
        exp_cnt = 0;
        exp_to  = 1'b0;
        run_len = 0;
    endtask

    task automatic set_dec(input logic v, input int rs, input int rt, input int rd, input logic w);
        dec_valid     = v;
        dec_rs        = REG_W'(rs);
        dec_rt        = REG_W'(rt);
        dec_rd        = REG_W'(rd);
        dec_reg_write = w;
    endtask

    // One clock: queue the expected ID/EX entry, advance, then score all stages.
    task automatic tick();
        ent_t e;
        ent_t gone;
        logic hold;
        e = '0;
        if (!flush && !insert_nop) begin
            e.rs    = dec_rs;
            e.rt    = dec_rt;
            e.rd    = dec_rd;
            e.valid = dec_valid;
            e.wr    = dec_reg_write & dec_valid;
        end
        hold = insert_nop & ~flush;
        if (hold) begin
            if (exp_cnt < 15) exp_cnt++;
            run_len++;
            if (run_len >= STALL_MAX) exp_to = 1'b1;
        end else begin
            run_len = 0;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        gone = exp_q.pop_front();
        total++;
        if (id_ex_obs !== exp_q[2]) begin
            bad++;
            $display("FAIL sb_id_ex t=%0t got=%h want=%h", $time, id_ex_obs, exp_q[2]);
        end
        total++;
        if (ex_mem_obs !== exp_q[1]) begin
            bad++;
            $display("FAIL sb_ex_mem t=%0t got=%h want=%h", $time, ex_mem_obs, exp_q[1]);
        end
        total++;
        if (mem_wb_obs !== exp_q[0]) begin
            bad++;
            $display("FAIL sb_mem_wb t=%0t got=%h want=%h (retired %h)", $time, mem_wb_obs, exp_q[0], gone);
        end
        total++;
        if (stall_cnt !== CNT_W'(exp_cnt)) begin
            bad++;
            $display("FAIL sb_stall_cnt t=%0t got=%0d want=%0d", $time, stall_cnt, exp_cnt);
        end
        total++;
        if (stall_timeout !== exp_to) begin
            bad++;
            $display("FAIL sb_timeout t=%0t got=%b want=%b", $time, stall_timeout, exp_to);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        insert_nop = 1'b0;
        flush = 1'b0;
        set_dec(1'b0, 0, 0, 0, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_dec(1'b1, 7, 6, 5, 1'b1);
        insert_nop = 1'b1;
        #12;
        total++;
        if ({id_ex_obs, ex_mem_obs, mem_wb_obs, stall_cnt, stall_timeout} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {id_ex_obs, ex_mem_obs, mem_wb_obs, stall_cnt, stall_timeout});
        end
        total++;
        if (fd_hold !== 1'b0) begin
            bad++;
            $display("FAIL reset_fd_hold got=%b want=0", fd_hold);
        end
        apply_reset();
    endtask

    task automatic test_stream();
        set_dec(1'b1, 1, 2, 3, 1'b1);
        tick();
        total++;
        if (id_ex_rd !== 3'd3 || id_ex_wr !== 1'b1) begin
            bad++;
            $display("FAIL stream_id_ex got rd=%0d wr=%b want rd=3 wr=1", id_ex_rd, id_ex_wr);
        end
        set_dec(1'b0, 4, 4, 4, 1'b1);
        tick();
        total++;
        if (ex_mem_rd !== 3'd3) begin
            bad++;
            $display("FAIL stream_ex_mem got rd=%0d want rd=3", ex_mem_rd);
        end
        total++;
        if (id_ex_valid !== 1'b0 || id_ex_wr !== 1'b0 || id_ex_rd !== 3'd4) begin
            bad++;
            $display("FAIL stream_invalid got v=%b wr=%b rd=%0d want v=0 wr=0 rd=4",
                     id_ex_valid, id_ex_wr, id_ex_rd);
        end
        tick();
        total++;
        if (mem_wb_rd !== 3'd3 || mem_wb_valid !== 1'b1) begin
            bad++;
            $display("FAIL stream_mem_wb got rd=%0d v=%b want rd=3 v=1", mem_wb_rd, mem_wb_valid);
        end
    endtask

    task automatic test_single_stall();
        apply_reset();
        set_dec(1'b1, 1, 1, 2, 1'b1);
        tick();
        set_dec(1'b1, 0, 0, 5, 1'b1);
        insert_nop = 1'b1;
        #1;
        total++;
        if (fd_hold !== 1'b1) begin
            bad++;
            $display("FAIL stall_fd_hold got=%b want=1", fd_hold);
        end
        tick();
        insert_nop = 1'b0;
        total++;
        if (id_ex_valid !== 1'b0 || ex_mem_rd !== 3'd2 || ex_mem_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_bubble got idv=%b exrd=%0d exv=%b want idv=0 exrd=2 exv=1",
                     id_ex_valid, ex_mem_rd, ex_mem_valid);
        end
        total++;
        if (stall_cnt !== 4'd1) begin
            bad++;
            $display("FAIL stall_count got=%0d want=1", stall_cnt);
        end
        tick();
        total++;
        if (id_ex_rd !== 3'd5 || id_ex_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_resume got rd=%0d v=%b want rd=5 v=1", id_ex_rd, id_ex_valid);
        end
    endtask

    task automatic test_flush_beats_stall();
        apply_reset();
        set_dec(1'b1, 3, 3, 6, 1'b1);
        insert_nop = 1'b1;
        flush = 1'b1;
        #1;
        total++;
        if (fd_hold !== 1'b0) begin
            bad++;
            $display("FAIL flush_fd_hold got=%b want=0", fd_hold);
        end
        tick();
        total++;
        if (id_ex_valid !== 1'b0 || id_ex_rd !== 3'd0 || stall_cnt !== 4'd0) begin
            bad++;
            $display("FAIL flush_bubble got v=%b rd=%0d cnt=%0d want v=0 rd=0 cnt=0",
                     id_ex_valid, id_ex_rd, stall_cnt);
        end
        insert_nop = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_watchdog();
        apply_reset();
        insert_nop = 1'b1;
        repeat (7) tick();
        insert_nop = 1'b0;
        tick();
        total++;
        if (stall_timeout !== 1'b0) begin
            bad++;
            $display("FAIL wd_seven got=%b want=0", stall_timeout);
        end
        insert_nop = 1'b1;
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (4) tick();
        total++;
        if (stall_timeout !== 1'b0) begin
            bad++;
            $display("FAIL wd_flush_break got=%b want=0", stall_timeout);
        end
        insert_nop = 1'b0;
        tick();
        insert_nop = 1'b1;
        repeat (7) tick();
        total++;
        if (stall_timeout !== 1'b0) begin
            bad++;
            $display("FAIL wd_before_eighth got=%b want=0", stall_timeout);
        end
        tick();
        total++;
        if (stall_timeout !== 1'b1) begin
            bad++;
            $display("FAIL wd_eighth got=%b want=1", stall_timeout);
        end
        insert_nop = 1'b0;
        repeat (2) tick();
        total++;
        if (stall_timeout !== 1'b1) begin
            bad++;
            $display("FAIL wd_sticky got=%b want=1", stall_timeout);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        insert_nop = 1'b1;
        repeat (20) tick();
        insert_nop = 1'b0;
        total++;
        if (stall_cnt !== 4'd15) begin
            bad++;
            $display("FAIL sat_count got=%0d want=15", stall_cnt);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            set_dec(1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), 1'($urandom));
            insert_nop = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 5) == 0);
            tick();
        end
        insert_nop = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        set_dec(1'b1, 1, 2, 3, 1'b1);
        tick();
        set_dec(1'b1, 4, 5, 6, 1'b1);
        tick();
        insert_nop = 1'b1;
        repeat (2) tick();
        #3;
        rst = 1'b0;
        #1;
        total++;
        if ({id_ex_obs, ex_mem_obs, mem_wb_obs, stall_cnt, stall_timeout} !== '0) begin
            bad++;
            $display("FAIL async_clear got=%h want=0",
                     {id_ex_obs, ex_mem_obs, mem_wb_obs, stall_cnt, stall_timeout});
        end
        total++;
        if (fd_hold !== 1'b0) begin
            bad++;
            $display("FAIL async_fd_hold got=%b want=0", fd_hold);
        end
        model_reset();
        #2;
        rst = 1'b1;
        repeat (3) tick();
        insert_nop = 1'b0;
        tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_single_stall();
        test_flush_beats_stall();
        test_watchdog();
        test_saturation();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
